uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter that responds to the CPU's MEM-stage load/store bus (address, MemRead, MemWrite, write data).
- Sits beside the data memory. CPU stores queue bytes into a TX FIFO; a baud-rate state machine serialises them as 8N1 frames on a pin.
- CPU loads return status and control.
- Responder only; never stalls the pipeline.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- BASE_ADDR, 32'h4000_0020, byte address of register 0; 16-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  byte address from EX/MEM ALU result.
- mem_read  in  1  load strobe.
- mem_write  in  1  store strobe.
- write_data  in  32  store data.
- read_data  out  32  load data (combinational).
- hit  out  1  addr within BASE_ADDR..BASE_ADDR+15; used by top-level read mux.
- tx  out  1  serial line, idle high.

Behaviour:
- Register map (word offsets; addr[1:0] ignored):
  - +0 TXDATA: write pushes write_data[7:0]; reads 0.
  - +4 STATUS (read): bit0 busy (FSM not IDLE), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky), bits[14:8] fifo count; other bits 0.
  - +4 STATUS (write): a 1 in bit3 clears overflow.
  - +8 CTRL: bit0 tx_enable (reset 1); read/write.
  - +12: reads 0, writes ignored.
- read_data = selected register when hit && mem_read, else 32'h0. Purely combinational, same cycle.
- Writes take effect at the rising clk edge where hit && mem_write.
- FIFO:
  - Circular, read/write pointers with wrap at FIFO_DEPTH; count register 0..FIFO_DEPTH.
  - Push when full: byte dropped, overflow set. Full is evaluated before a same-cycle pop, so a push coinciding with a pop from a full FIFO is still dropped.
  - Pop and push in the same cycle on a non-full FIFO: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If tx_enable && !fifo_empty: pop into shift reg, bit_idx=0, baud_cnt=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0], LSB first. Each CLKS_PER_BIT cycles shift right and bit_idx++. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE. The next byte may pop on the first IDLE cycle, giving exactly 1 idle clock between frames.
- baud_cnt counts 0..CLKS_PER_BIT-1 and wraps; a state/bit advance occurs on the wrap.
- Latency: store at edge N with empty FIFO and IDLE FSM → pop at edge N+1 → tx low from edge N+1. Frame = 10*CLKS_PER_BIT cycles.
- Clearing tx_enable mid-frame: the current frame completes; no further pops. The FIFO still accepts pushes.
- Reset (asynchronous, any time including mid-frame):
  - tx=1 immediately; FSM IDLE.
  - FIFO emptied, count=0, overflow=0, tx_enable=1, baud_cnt=0, bit_idx=0.
  - read_data follows the reset register values.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP that transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT. CTRL bit1 parity_odd (reset 0) inverts the parity bit.
- Undefined: 8N1 only; CTRL bit1 reads 0 and writes to it are ignored.

Decomposition:
- Shared package holds:
  - register offset constants (OFF_TXDATA=0, OFF_STATUS=4, OFF_CTRL=8);
  - STATUS/CTRL bit-position constants;
  - FSM state encoding (2-bit; 3-bit with parity).
- Natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count), reusable for a later UART RX peripheral.
- Bus decode and the FSM stay in uart_tx_mmio.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then read STATUS → 32'h0000_0004 (empty); read CTRL → 1; tx=1.
- Store 8'hA5 to +0 → tx goes 0 one cycle later. Bits sampled mid-bit: 0, 1,0,1,0,0,1,0,1, 1, each 4 cycles; busy=1 during the frame, 0 after 40 cycles.
- Five back-to-back stores while CTRL=0 → STATUS count=4, full=1, overflow=1. Write 8 to STATUS → overflow=0, count still 4.
- Set CTRL=1 with 4 bytes queued → four frames of 40 cycles, each separated by exactly 1 idle cycle; empty=1 at the end.
- Assert reset 15 cycles into a frame → tx=1 asynchronously. After release, STATUS=32'h4 and no residual frame is sent.
- Load from BASE_ADDR+16 → hit=0, read_data=0; load from +12 → hit=1, read_data=0.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS/CTRL bit positions and the transmit FSM encoding.
// Optional feature macro: UART_TX_PARITY_EN (adds a parity bit per frame).
package uart_tx_mmio_pkg;

  // Register byte offsets within the 16-byte window (addr[1:0] ignored).
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_RSVD   = 4'hC;

  // STATUS bit positions.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 7;

  // CTRL bit positions.
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PAR_ODD  = 1;

  // Transmit FSM encoding; the parity build needs a fifth state.
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous circular FIFO with occupancy count. A push into a full FIFO is
// dropped even if a pop happens in the same cycle; a pop from an empty FIFO
// is ignored. dout always shows the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_MAX);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and count next-state; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter on the MEM-stage load/store bus.
// Stores to TXDATA queue bytes; a baud-rate FSM sends them as 8N1 frames.
// Optional feature macro: UART_TX_PARITY_EN (8E1/8O1 frames, CTRL bit1 = odd).
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        tx
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  // Bus decode.
  logic [3:0] reg_off;
  logic       wr_en, push;
  logic       unused_bits;

  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off     = {addr[3:2], 2'b00};
  assign wr_en       = hit && mem_write;
  assign push        = wr_en && (reg_off == OFF_TXDATA);
  assign unused_bits = ^{addr[1:0], write_data[31:8]};

  // FIFO.
  logic [7:0]       fifo_dout;
  logic             fifo_full, fifo_empty, pop;
  logic [CNT_W-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (write_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control/status registers.
  logic overflow_q, overflow_d;
  logic tx_enable_q, tx_enable_d;
  logic parity_odd_q;
`ifdef UART_TX_PARITY_EN
  logic parity_odd_d;
`endif

  // Sticky overflow, enable and parity-mode updates from bus writes.
  always_comb begin
    overflow_d  = overflow_q;
    tx_enable_d = tx_enable_q;
    if (push && fifo_full) begin
      overflow_d = 1'b1;
    end else if (wr_en && (reg_off == OFF_STATUS) && write_data[STAT_OVF]) begin
      overflow_d = 1'b0;
    end
    if (wr_en && (reg_off == OFF_CTRL)) tx_enable_d = write_data[CTRL_EN];
`ifdef UART_TX_PARITY_EN
    parity_odd_d = parity_odd_q;
    if (wr_en && (reg_off == OFF_CTRL)) parity_odd_d = write_data[CTRL_PAR_ODD];
`endif
  end

  // Control/status register flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      tx_enable_q <= 1'b1;
    end else begin
      overflow_q  <= overflow_d;
      tx_enable_q <= tx_enable_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity mode flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_odd_q <= 1'b0;
    else       parity_odd_q <= parity_odd_d;
  end
`else
  assign parity_odd_q = 1'b0;
`endif

  // Transmit FSM state.
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign pop       = (state_q == ST_IDLE) && tx_enable_q && !fifo_empty;
  assign baud_wrap = (baud_cnt_q == BAUD_MAX);
  assign tx        = tx_q;

  // Readback words.
  logic [31:0] status_word, ctrl_word;

  // Assemble STATUS and CTRL readback values.
  always_comb begin
    status_word                                 = '0;
    status_word[STAT_BUSY]                      = (state_q != ST_IDLE);
    status_word[STAT_FULL]                      = fifo_full;
    status_word[STAT_EMPTY]                     = fifo_empty;
    status_word[STAT_OVF]                       = overflow_q;
    status_word[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(fifo_count);
    ctrl_word                                   = '0;
    ctrl_word[CTRL_EN]                          = tx_enable_q;
    ctrl_word[CTRL_PAR_ODD]                     = parity_odd_q;
  end

  // Combinational load data; zero unless this block is addressed by a load.
  always_comb begin
    read_data = '0;
    if (hit && mem_read) begin
      case (reg_off)
        OFF_STATUS: read_data = status_word;
        OFF_CTRL:   read_data = ctrl_word;
        default:    read_data = '0;
      endcase
    end
  end

  // FSM next-state: every state lasts CLKS_PER_BIT cycles, advancing on baud wrap.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (pop) begin
          shift_d   = fifo_dout;
          bit_idx_d = 3'd0;
          state_d   = ST_START;
          tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^fifo_dout) ^ parity_odd_q;
`endif
        end
      end
      ST_START: begin
        if (baud_wrap) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_wrap) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_wrap) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_wrap) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
        tx_d       = 1'b1;
      end
    endcase
  end

  // FSM registers with registered serial output; reset forces the line idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        hit;
  logic        tx;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_mmio #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .write_data (write_data),
    .read_data  (read_data),
    .hit        (hit),
    .tx         (tx)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One store; the write lands on the rising edge inside this task.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr       = a;
    write_data = d;
    mem_write  = 1'b1;
    @(negedge clk);
    mem_write  = 1'b0;
    addr       = '0;
    write_data = '0;
  endtask

  // Combinational load, no clock edge consumed.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    addr     = a;
    mem_read = 1'b1;
    #1;
    d        = read_data;
    h        = hit;
    mem_read = 1'b0;
    addr     = '0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        h;
    logic [9:0]  frame;
    logic [7:0]  bytes_q [4];
    int          lows;

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_read(BASE + 32'd4, rd, h);
    check("reset_status", rd, 32'h0000_0004);
    check("reset_status_hit", {31'd0, h}, 32'd1);
    bus_read(BASE + 32'd8, rd, h);
    check("reset_ctrl", rd, 32'h0000_0001);
    check("reset_tx", {31'd0, tx}, 32'd1);

    // Single frame of 8'hA5: start, LSB-first data, stop.
    frame = 10'b1_1010_0101_0;
    bus_write(BASE, 32'h0000_00A5);
    check("tx_before_start", {31'd0, tx}, 32'd1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("a5_bit%0d", i), {31'd0, tx}, {31'd0, frame[i]});
      if (i == 5) begin
        bus_read(BASE + 32'd4, rd, h);
        check("a5_busy", {31'd0, rd[0]}, 32'd1);
      end
      if (i < 9) repeat (4) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    bus_read(BASE + 32'd4, rd, h);
    check("a5_done_status", rd, 32'h0000_0004);

    // Disabled transmitter: fill FIFO and overflow it.
    bus_write(BASE + 32'd8, 32'd0);
    bus_write(BASE, 32'h11);
    bus_write(BASE, 32'h22);
    bus_write(BASE, 32'h33);
    bus_write(BASE, 32'h44);
    bus_write(BASE, 32'h55);
    bus_read(BASE + 32'd4, rd, h);
    check("full_ovf_status", rd, 32'h0000_040A);
    check("disabled_tx_idle", {31'd0, tx}, 32'd1);
    bus_read(BASE + 32'd8, rd, h);
    check("ctrl_zero", rd, 32'h0000_0000);
    bus_write(BASE + 32'd4, 32'd8);
    bus_read(BASE + 32'd4, rd, h);
    check("ovf_cleared", rd, 32'h0000_0402);

    // Enable: four back-to-back frames with a single idle clock between them.
    bytes_q[0] = 8'h11;
    bytes_q[1] = 8'h22;
    bytes_q[2] = 8'h33;
    bytes_q[3] = 8'h44;
    bus_write(BASE + 32'd8, 32'd1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      frame = {1'b1, bytes_q[k], 1'b0};
      for (int i = 0; i < 10; i++) begin
        check($sformatf("f%0d_bit%0d", k, i), {31'd0, tx}, {31'd0, frame[i]});
        if (i < 9) repeat (4) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      check($sformatf("f%0d_gap_tx", k), {31'd0, tx}, 32'd1);
      bus_read(BASE + 32'd4, rd, h);
      check($sformatf("f%0d_gap_status", k), rd,
            ((32'd3 - 32'(k)) << 8) | ((k == 3) ? 32'd4 : 32'd0));
      @(negedge clk);
      check($sformatf("f%0d_next_start", k), {31'd0, tx}, (k < 3) ? 32'd0 : 32'd1);
      repeat (2) @(negedge clk);
    end

    // Asynchronous reset in the middle of a frame of 8'h00.
    bus_write(BASE, 32'h0000_0000);
    repeat (15) @(negedge clk);
    check("pre_reset_tx_low", {31'd0, tx}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_tx", {31'd0, tx}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_read(BASE + 32'd4, rd, h);
    check("post_reset_status", rd, 32'h0000_0004);
    bus_read(BASE + 32'd8, rd, h);
    check("post_reset_ctrl", rd, 32'h0000_0001);
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_residual_frame", 32'(lows), 32'd0);

    // Address decode boundaries.
    bus_read(BASE + 32'd16, rd, h);
    check("out_of_range_hit", {31'd0, h}, 32'd0);
    check("out_of_range_data", rd, 32'd0);
    bus_read(BASE + 32'd12, rd, h);
    check("rsvd_hit", {31'd0, h}, 32'd1);
    check("rsvd_data", rd, 32'd0);
    bus_read(BASE, rd, h);
    check("txdata_reads_zero", rd, 32'd0);
    bus_read(BASE - 32'd4, rd, h);
    check("below_range_hit", {31'd0, h}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
